sd_spi_responder: RTL and testbench

SPI-mode SD card emulator that answers the SD host session engine from the card side. It samples csn/sck/mosi, decodes 6-byte SD commands, returns R1/R3/R7 responses, and streams 512-byte single-block reads from a byte-wide backing memory port. It is used as the card model in system benches and as a card stand-in on FPGA loopback builds.

---
 rtl/sd_spi_responder.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_sd_spi_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: decodes host commands, answers R1/R3/R7,
// and streams single 512-byte block reads from a byte-wide memory port.
module sd_spi_responder #(
  parameter int          NCR          = 1,
  parameter int          NAC          = 4,
  parameter int          INIT_RETRIES = 2,
  parameter logic [31:0] OCR          = 32'hC0FF8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csn,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        card_idle,
  output logic        mem_rreq,
  output logic [31:0] mem_sector,
  output logic [8:0]  mem_idx,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {
    RX_CMD, GAP, RESP, NACW, TOKEN, DATA, CRC
  } state_t;

  state_t      state, state_n;
  logic [1:0]  csn_q, sck_q, mosi_q;
  logic        sck_d;
  logic        sel, rise, fall, done, exec;
  logic [2:0]  bitcnt;
  logic [6:0]  rx_shift;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte, tx_n;
  logic [9:0]  cnt, cnt_n;
  logic [2:0]  cmd_cnt;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [39:0] resp_buf;
  logic        resp_long, resp_data;
  logic        app;
  logic [7:0]  retry;
  logic [7:0]  r1;
  logic [31:0] tail;
  logic        long_r, data_r;
  logic        rreq_n, rreq_d;
  logic [7:0]  pf;

  assign sel     = ~csn_q[1];
  assign rise    = sel & sck_q[1] & ~sck_d;
  assign fall    = sel & ~sck_q[1] & sck_d;
  assign done    = rise & (bitcnt == 3'd7);
  assign rx_byte = {rx_shift, mosi_q[1]};
  assign exec    = done & (state == RX_CMD) & (cmd_cnt == 3'd5);

  // two-flop synchronizers plus sck history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csn_q  <= 2'b11;
      sck_q  <= 2'b11;
      mosi_q <= 2'b11;
      sck_d  <= 1'b1;
    end else begin
      csn_q  <= {csn_q[0], csn};
      sck_q  <= {sck_q[0], sck};
      mosi_q <= {mosi_q[0], mosi};
      sck_d  <= sck_q[1];
    end
  end

  // bit framing: shift in on rising sck, drive miso on falling sck
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt   <= 3'd0;
      rx_shift <= 7'd0;
      miso     <= 1'b1;
    end else if (!sel) begin
      bitcnt <= 3'd0;
      miso   <= 1'b1;
    end else begin
      if (rise) begin
        rx_shift <= rx_byte[6:0];
        bitcnt   <= bitcnt + 3'd1;
      end
      if (fall) miso <= tx_byte[~bitcnt];
    end
  end

  // response bytes for the command currently held in idx_q/arg_q
  always_comb begin
    r1     = {5'b0, 1'b1, 1'b0, card_idle};
    tail   = 32'hFFFF_FFFF;
    long_r = 1'b0;
    data_r = 1'b0;
    unique case (1'b1)
      idx_q == 6'd0: r1 = 8'h01;
      idx_q == 6'd8: begin
        r1     = {7'b0, card_idle};
        tail   = {20'h0, arg_q[11:0]};
        long_r = 1'b1;
      end
      idx_q == 6'd55: r1 = {7'b0, card_idle};
      idx_q == 6'd41 && app:
        r1 = (retry < 8'(INIT_RETRIES)) ? 8'h01 : 8'h00;
      idx_q == 6'd58: begin
        r1     = {7'b0, card_idle};
        tail   = OCR;
        long_r = 1'b1;
      end
      idx_q == 6'd17: begin
        r1     = card_idle ? 8'h05 : 8'h00;
        data_r = ~card_idle;
      end
      default: ;
    endcase
  end

  // byte-level sequencing: chooses the next tx byte at each byte boundary
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tx_n    = tx_byte;
    if (done) begin
      unique case (state)
        RX_CMD: begin
          tx_n = 8'hFF;
          if (exec) begin
            state_n = GAP;
            cnt_n   = 10'd0;
          end
        end
        GAP: begin
          if (cnt == 10'(NCR - 1)) begin
            state_n = RESP;
            cnt_n   = 10'd0;
            tx_n    = resp_buf[39:32];
          end else begin
            cnt_n = cnt + 10'd1;
            tx_n  = 8'hFF;
          end
        end
        RESP: begin
          if (cnt == (resp_long ? 10'd4 : 10'd0)) begin
            state_n = resp_data ? NACW : RX_CMD;
            cnt_n   = 10'd0;
            tx_n    = 8'hFF;
          end else begin
            cnt_n = cnt + 10'd1;
            tx_n  = resp_buf[31:24];
          end
        end
        NACW: begin
          if (cnt == 10'(NAC - 1)) begin
            state_n = TOKEN;
            cnt_n   = 10'd0;
            tx_n    = 8'hFE;
          end else begin
            cnt_n = cnt + 10'd1;
            tx_n  = 8'hFF;
          end
        end
        TOKEN: begin
          state_n = DATA;
          cnt_n   = 10'd0;
          tx_n    = pf;
        end
        DATA: begin
          if (cnt == 10'd511) begin
            state_n = CRC;
            cnt_n   = 10'd0;
            tx_n    = 8'hFF;
          end else begin
            cnt_n = cnt + 10'd1;
            tx_n  = pf;
          end
        end
        CRC: begin
          tx_n = 8'hFF;
          if (cnt == 10'd1) begin
            state_n = RX_CMD;
            cnt_n   = 10'd0;
          end else begin
            cnt_n = cnt + 10'd1;
          end
        end
        default: begin
          state_n = RX_CMD;
          cnt_n   = 10'd0;
          tx_n    = 8'hFF;
        end
      endcase
    end
  end

  // sequencer state; deselect aborts back to command reception
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_CMD;
      cnt     <= 10'd0;
      tx_byte <= 8'hFF;
    end else if (!sel) begin
      state   <= RX_CMD;
      cnt     <= 10'd0;
      tx_byte <= 8'hFF;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      tx_byte <= tx_n;
    end
  end

  // command assembly, execution and card status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_cnt    <= 3'd0;
      idx_q      <= 6'd0;
      arg_q      <= 32'd0;
      cmd_valid  <= 1'b0;
      cmd_index  <= 6'd0;
      cmd_arg    <= 32'd0;
      card_idle  <= 1'b1;
      app        <= 1'b0;
      retry      <= 8'd0;
      resp_buf   <= 40'hFF_FFFF_FFFF;
      resp_long  <= 1'b0;
      resp_data  <= 1'b0;
      mem_sector <= 32'd0;
    end else begin
      cmd_valid <= exec;
      if (!sel) begin
        cmd_cnt <= 3'd0;
      end else if (done && state == RX_CMD) begin
        if (cmd_cnt == 3'd0) begin
          if (rx_byte[7:6] == 2'b01) begin
            idx_q   <= rx_byte[5:0];
            cmd_cnt <= 3'd1;
          end
        end else if (cmd_cnt == 3'd5) begin
          cmd_cnt <= 3'd0;
        end else begin
          arg_q   <= {arg_q[23:0], rx_byte};
          cmd_cnt <= cmd_cnt + 3'd1;
        end
      end
      if (done && state == RESP)
        resp_buf <= {resp_buf[31:0], 8'hFF};
      if (exec) begin
        cmd_index <= idx_q;
        cmd_arg   <= arg_q;
        resp_buf  <= {r1, tail};
        resp_long <= long_r;
        resp_data <= data_r;
        app       <= (idx_q == 6'd55);
        if (idx_q == 6'd17) mem_sector <= arg_q;
        if (idx_q == 6'd0) begin
          card_idle <= 1'b1;
          retry     <= 8'd0;
        end else if (idx_q == 6'd41 && app) begin
          if (retry < 8'(INIT_RETRIES)) retry <= retry + 8'd1;
          else card_idle <= 1'b0;
        end
      end
    end
  end

  assign rreq_n = rise && (bitcnt == 3'd3) &&
                  ((state == NACW && cnt == 10'(NAC - 1)) ||
                   (state == DATA && cnt != 10'd511));

  // block data prefetch one byte ahead of transmission
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rreq <= 1'b0;
      mem_idx  <= 9'd0;
      rreq_d   <= 1'b0;
      pf       <= 8'hFF;
    end else begin
      mem_rreq <= rreq_n;
      rreq_d   <= mem_rreq;
      if (rreq_n) mem_idx <= (state == NACW) ? 9'd0 : cnt[8:0] + 9'd1;
      if (rreq_d) pf <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: table of commands plus block-read,
// abort and reset sequences, checked through a miso byte scoreboard.
module tb_sd_spi_responder;

  localparam int NCR = 1;
  localparam int NAC = 4;
  localparam int HP  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csn = 1'b1;
  logic        sck = 1'b1;
  logic        mosi = 1'b1;
  logic        miso;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        card_idle;
  logic        mem_rreq;
  logic [31:0] mem_sector;
  logic [8:0]  mem_idx;
  logic [7:0]  mem_rdata = 8'h00;

  int total = 0;
  int bad = 0;
  int nvalid = 0;
  int rq_cnt = 0;
  int idx_bad = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  crc;
    int          nresp;
    logic [39:0] resp;
    logic        idle;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  sd_spi_responder #(
    .NCR(NCR), .NAC(NAC), .INIT_RETRIES(2), .OCR(32'hC0FF8000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .csn(csn), .sck(sck), .mosi(mosi),
    .miso(miso), .cmd_valid(cmd_valid), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .card_idle(card_idle), .mem_rreq(mem_rreq),
    .mem_sector(mem_sector), .mem_idx(mem_idx), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) if (mem_rreq) mem_rdata <= mem_idx[7:0];
  always @(posedge clk) if (cmd_valid) nvalid++;
  always @(posedge clk)
    if (mem_rreq) begin
      if (mem_idx != rq_cnt[8:0]) idx_bad++;
      rq_cnt++;
    end

  task automatic chk(input string name, input logic [39:0] act,
                     input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      sck = 1'b0;
      mosi = tx[i];
      tick(HP);
      rx[i] = miso;
      sck = 1'b1;
      tick(HP);
    end
  endtask

  task automatic xchg(input logic [7:0] tx);
    logic [7:0] rx;
    xfer(tx, rx);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got %0h want none", rx);
    end else begin
      chk("miso_byte", 40'(rx), 40'(sb.pop_front()));
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [7:0] crc);
    logic [47:0] f;
    f = {2'b01, idx, arg, crc};
    for (int k = 0; k < 6; k++) sb.push_back(8'hFF);
    for (int k = 0; k < 6; k++) xchg(f[47-8*k -: 8]);
  endtask

  task automatic issue(input vec_t v);
    int nv0;
    nv0 = nvalid;
    send_cmd(v.idx, v.arg, v.crc);
    for (int k = 0; k < NCR; k++) sb.push_back(8'hFF);
    for (int k = 0; k < v.nresp; k++) sb.push_back(v.resp[39-8*k -: 8]);
    for (int k = 0; k < NCR + v.nresp; k++) xchg(8'hFF);
    chk("cmd_valid_cnt", 40'(nvalid - nv0), 40'd1);
    chk("cmd_index", 40'(cmd_index), 40'(v.idx));
    chk("cmd_arg", 40'(cmd_arg), 40'(v.arg));
    chk("card_idle", 40'(card_idle), 40'(v.idle));
  endtask

  task automatic init_rounds;
    for (int i = 2; i < 8; i++) issue(vecs[i]);
  endtask

  task automatic start_read(input logic [31:0] arg, input int nbytes);
    send_cmd(6'd17, arg, 8'hFF);
    for (int k = 0; k < NCR; k++) sb.push_back(8'hFF);
    sb.push_back(8'h00);
    for (int k = 0; k < NAC; k++) sb.push_back(8'hFF);
    sb.push_back(8'hFE);
    for (int k = 0; k < nbytes; k++) sb.push_back(8'(k));
    for (int k = 0; k < NCR + 2 + NAC + nbytes; k++) xchg(8'hFF);
  endtask

  initial begin
    int rq0, ib0;
    vec_t v13;

    vecs[0] = '{6'd0,  32'h0,        8'h95, 1, 40'h01_FFFF_FFFF, 1'b1};
    vecs[1] = '{6'd8,  32'h0000_01AA, 8'h87, 5, 40'h01_0000_01AA, 1'b1};
    vecs[2] = '{6'd55, 32'h0,        8'h65, 1, 40'h01_FFFF_FFFF, 1'b1};
    vecs[3] = '{6'd41, 32'h4000_0000, 8'h77, 1, 40'h01_FFFF_FFFF, 1'b1};
    vecs[4] = '{6'd55, 32'h0,        8'h65, 1, 40'h01_FFFF_FFFF, 1'b1};
    vecs[5] = '{6'd41, 32'h4000_0000, 8'h77, 1, 40'h01_FFFF_FFFF, 1'b1};
    vecs[6] = '{6'd55, 32'h0,        8'h65, 1, 40'h01_FFFF_FFFF, 1'b1};
    vecs[7] = '{6'd41, 32'h4000_0000, 8'h77, 1, 40'h00_FFFF_FFFF, 1'b0};
    vecs[8] = '{6'd58, 32'h0,        8'hFD, 5, 40'h00_C0FF_8000, 1'b0};
    v13     = '{6'd13, 32'h0,        8'hFF, 1, 40'h05_FFFF_FFFF, 1'b1};

    tick(4);
    chk("rst_miso", 40'(miso), 40'd1);
    chk("rst_cmd_valid", 40'(cmd_valid), 40'd0);
    chk("rst_card_idle", 40'(card_idle), 40'd1);
    chk("rst_mem_rreq", 40'(mem_rreq), 40'd0);
    chk("rst_cmd_index", 40'(cmd_index), 40'd0);
    rst_n = 1'b1;
    tick(4);
    csn = 1'b0;
    tick(4);

    for (int i = 0; i < 9; i++) issue(vecs[i]);

    rq0 = rq_cnt;
    ib0 = idx_bad;
    start_read(32'd5, 512);
    sb.push_back(8'hFF);
    sb.push_back(8'hFF);
    xchg(8'hFF);
    xchg(8'hFF);
    chk("rd_index", 40'(cmd_index), 40'd17);
    chk("rd_sector", 40'(mem_sector), 40'd5);
    chk("rd_rreq_cnt", 40'(rq_cnt - rq0), 40'd512);
    chk("rd_idx_seq", 40'(idx_bad - ib0), 40'd0);

    issue(vecs[0]);
    send_cmd(6'd17, 32'd7, 8'hFF);
    for (int k = 0; k < NCR; k++) sb.push_back(8'hFF);
    sb.push_back(8'h05);
    for (int k = 0; k < 32; k++) sb.push_back(8'hFF);
    for (int k = 0; k < NCR + 1 + 32; k++) xchg(8'hFF);
    chk("idle_rd_sector", 40'(mem_sector), 40'd7);
    issue(v13);

    init_rounds();
    start_read(32'd9, 100);
    sck = 1'b0;
    mosi = 1'b1;
    tick(HP);
    chk("abort_bit7", 40'(miso), 40'd0);
    csn = 1'b1;
    tick(4);
    chk("abort_miso", 40'(miso), 40'd1);
    sck = 1'b1;
    tick(8);
    csn = 1'b0;
    tick(4);
    issue(vecs[0]);

    init_rounds();
    send_cmd(6'd58, 32'h0, 8'hFD);
    for (int k = 0; k < NCR; k++) sb.push_back(8'hFF);
    sb.push_back(8'h00);
    sb.push_back(8'hC0);
    for (int k = 0; k < NCR + 2; k++) xchg(8'hFF);
    chk("pre_rst_idle", 40'(card_idle), 40'd0);
    sck = 1'b0;
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("mrst_miso", 40'(miso), 40'd1);
    chk("mrst_cmd_valid", 40'(cmd_valid), 40'd0);
    chk("mrst_cmd_index", 40'(cmd_index), 40'd0);
    chk("mrst_cmd_arg", 40'(cmd_arg), 40'd0);
    chk("mrst_card_idle", 40'(card_idle), 40'd1);
    chk("mrst_mem_rreq", 40'(mem_rreq), 40'd0);
    chk("mrst_mem_sector", 40'(mem_sector), 40'd0);
    chk("mrst_mem_idx", 40'(mem_idx), 40'd0);
    sck = 1'b1;
    csn = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(4);
    chk("sb_drain", 40'(sb.size()), 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
